// File: rtl/dec_pkg.sv
// dec_pkg: mode codes and SWEEP state encodings shared by the scan_decoder slice
package dec_pkg;
    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } sweep_state_t;
endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control inputs and registered select outputs of scan_decoder
//   en, mode, sel, start : driven by master, consumed by the decoder
//   out, idx, busy, done : driven by the decoder
interface scan_decoder_if #(
    parameter int SEL_W = 4
);
    localparam int OUT_N = 1 << SEL_W;

    logic             en;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic             start;
    logic [OUT_N-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             busy;
    logic             done;

    modport master (output en, mode, sel, start, input out, idx, busy, done);
    modport slave  (input en, mode, sel, start, output out, idx, busy, done);
endinterface

// File: rtl/onehot_dec.sv
// onehot_dec: combinational index to one-hot (one-cold if ACTIVE_LOW) decode
//   idx   in  SEL_W       index to decode
//   valid in  1           0 forces every line inactive
//   out   out 2**SEL_W    decoded lines
module onehot_dec #(
    parameter int SEL_W      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [SEL_W-1:0]      idx,
    input  logic                  valid,
    output logic [(1<<SEL_W)-1:0] out
);
    localparam int OUT_N = 1 << SEL_W;

    logic [OUT_N-1:0] oh;

    assign oh  = valid ? ({{(OUT_N-1){1'b0}}, 1'b1} << idx) : '0;
    assign out = ACTIVE_LOW ? ~oh : oh;
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with DIRECT, free-running SCAN and one-shot SWEEP modes
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   bus   slave side of scan_decoder_if (en/mode/sel/start in; out/idx/busy/done out)
module scan_decoder
    import dec_pkg::*;
#(
    parameter int SEL_W      = 4,
    parameter int PRESCALE   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    scan_decoder_if.slave bus
);
    localparam int OUT_N = 1 << SEL_W;
    localparam int PW    = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PMAX     = PW'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IMAX     = '1;
    localparam logic [OUT_N-1:0] IDLE_OUT = {OUT_N{ACTIVE_LOW}};

    logic [1:0]       mode_q;
    sweep_state_t     state, state_d;
    logic [PW-1:0]    pre, pre_d;
    logic [SEL_W-1:0] idx_d;
    logic [OUT_N-1:0] out_d;
    logic             tick, val_d, busy_d, done_d;

    assign tick = pre == PMAX;

    // Outputs are registered from the next-state values so out always matches idx.
    always_comb begin
        state_d = state;
        pre_d   = pre;
        idx_d   = bus.idx;
        val_d   = 1'b0;
        done_d  = 1'b0;
        if (bus.mode != mode_q || bus.mode == MODE_RSVD) begin
            state_d = S_IDLE;
            pre_d   = '0;
            idx_d   = '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_DIRECT: begin
                    idx_d = bus.sel;
                    pre_d = '0;
                    val_d = 1'b1;
                end
                MODE_SCAN: begin
                    pre_d = tick ? '0 : pre + 1'b1;
                    idx_d = tick ? bus.idx + 1'b1 : bus.idx;
                    val_d = 1'b1;
                end
                MODE_SWEEP: begin
                    case (state)
                        S_IDLE: begin
                            if (bus.start) begin
                                state_d = S_RUN;
                                pre_d   = '0;
                                idx_d   = '0;
                                val_d   = 1'b1;
                            end
                        end
                        S_RUN: begin
                            pre_d = tick ? '0 : pre + 1'b1;
                            if (tick && bus.idx == IMAX) begin
                                state_d = S_DONE;
                                idx_d   = '0;
                                done_d  = 1'b1;
                            end else begin
                                idx_d = tick ? bus.idx + 1'b1 : bus.idx;
                                val_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
        busy_d = state_d == S_RUN;
    end

    onehot_dec #(.SEL_W(SEL_W), .ACTIVE_LOW(ACTIVE_LOW)) u_dec (
        .idx   (idx_d),
        .valid (val_d),
        .out   (out_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_DIRECT;
            state    <= S_IDLE;
            pre      <= '0;
            bus.idx  <= '0;
            bus.out  <= IDLE_OUT;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            mode_q   <= bus.mode;
            state    <= state_d;
            pre      <= pre_d;
            bus.idx  <= idx_d;
            bus.out  <= out_d;
            bus.busy <= busy_d;
            bus.done <= done_d;
        end
    end
endmodule
